// File: rtl/video_capture_pkg.sv
// Shared types for the video capture path: pixel/bus FSM states and the FIFO word layout.
package video_capture_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DROP} pix_state_t;
   typedef enum logic {WB_IDLE, WB_WRITE} wb_state_t;

   typedef struct packed {
      logic        sof;
      logic [23:0] rgb;
   } fifo_word_t;

   // Byte distance between consecutive pixels in the frame buffer.
   localparam int unsigned PIX_STRIDE = 4;

endpackage

// File: rtl/video_capture_if.sv
// Wishbone classic bus bundle between the capture block (master) and the SDRAM controller (slave).
interface video_capture_if;

   // Handshake: a transfer is offered while cyc and stb are both 1; the master holds adr,
   // dat_ms, sel and we stable until the slave returns ack=1, which completes it in that cycle.
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic [3:0]  sel;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;

   modport master (output adr, dat_ms, sel, cyc, stb, we, cti, bte,
                   input  ack, dat_sm);
   modport slave  (input  adr, dat_ms, sel, cyc, stb, we, cti, bte,
                   output ack, dat_sm);

endinterface

// File: rtl/async_fifo.sv
// Dual-clock FIFO with Gray-coded pointers and show-ahead read data (rdata valid while rempty=0).
module async_fifo #(
   parameter int DATA_WIDTH = 25,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  wfull,
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic                  read,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rempty
);

   localparam int AW = DEPTH_LOG2;

   logic [DATA_WIDTH-1:0] mem [0:(1<<AW)-1];
   logic [AW:0] wbin, wbin_n, wgray, rbin, rbin_n, rgray;
   logic [AW:0] rgray_w1, rgray_w2, wgray_r1, wgray_r2;

   function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   assign wbin_n = wbin + {{AW{1'b0}}, (write & ~wfull)};
   assign rbin_n = rbin + {{AW{1'b0}}, (read & ~rempty)};

   always_ff @(posedge wclk) begin
      if (write && !wfull) mem[wbin[AW-1:0]] <= wdata;
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin     <= '0;
         wgray    <= '0;
         rgray_w1 <= '0;
         rgray_w2 <= '0;
      end else begin
         wbin     <= wbin_n;
         wgray    <= bin2gray(wbin_n);
         rgray_w1 <= rgray;
         rgray_w2 <= rgray_w1;
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin     <= '0;
         rgray    <= '0;
         wgray_r1 <= '0;
         wgray_r2 <= '0;
      end else begin
         rbin     <= rbin_n;
         rgray    <= bin2gray(rbin_n);
         wgray_r1 <= wgray;
         wgray_r2 <= wgray_r1;
      end
   end

   // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
   assign wfull  = (wgray == {~rgray_w2[AW:AW-1], rgray_w2[AW-2:0]});
   assign rempty = (rgray == wgray_r2);
   assign rdata  = mem[rbin[AW-1:0]];

endmodule

// File: rtl/video_capture_wb_writer.sv
// Wishbone-domain side: pops FIFO words and writes one 32-bit word per pixel into the frame buffer.
module video_capture_wb_writer
   import video_capture_pkg::*;
#(
   parameter int          HDISP     = 800,
   parameter int          VDISP     = 480,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic            wshb_clk,
   input  logic            wshb_rst,
   input  fifo_word_t      rdata,
   input  logic            rempty,
   output logic            read,
   video_capture_if.master wshb
);

   localparam logic [31:0] STRIDE    = 32'(PIX_STRIDE);
   localparam logic [31:0] FRAME_END = BASE_ADDR + 32'(PIX_STRIDE * HDISP * VDISP);

   wb_state_t   state, state_n;
   logic        load;
   logic        aligned;
   logic        cyc_q;
   logic [31:0] adr_q, next_adr, adr_inc, dat_q;
   logic        unused_dat_sm;

   assign adr_inc = (adr_q + STRIDE == FRAME_END) ? BASE_ADDR : adr_q + STRIDE;

   // Until a sof word has been seen since reset, non-sof words are popped and dropped
   // so the first bus write always lands on pixel (0,0).
   always_comb begin
      state_n = state;
      read    = 1'b0;
      load    = 1'b0;
      case (state)
         WB_IDLE: begin
            if (!rempty) begin
               read = 1'b1;
               if (aligned || rdata.sof) begin
                  load    = 1'b1;
                  state_n = WB_WRITE;
               end
            end
         end
         WB_WRITE: begin
            if (wshb.ack) begin
               if (!rempty) begin
                  read = 1'b1;
                  load = 1'b1;
               end else begin
                  state_n = WB_IDLE;
               end
            end
         end
         default: state_n = WB_IDLE;
      endcase
   end

   always_ff @(posedge wshb_clk or posedge wshb_rst) begin
      if (wshb_rst) state <= WB_IDLE;
      else          state <= state_n;
   end

   always_ff @(posedge wshb_clk or posedge wshb_rst) begin
      if (wshb_rst) begin
         adr_q    <= BASE_ADDR;
         next_adr <= BASE_ADDR;
         dat_q    <= '0;
         cyc_q    <= 1'b0;
         aligned  <= 1'b0;
      end else begin
         if (state == WB_WRITE && wshb.ack) next_adr <= adr_inc;
         if (load) begin
            adr_q <= rdata.sof ? BASE_ADDR : ((state == WB_WRITE) ? adr_inc : next_adr);
            dat_q <= {8'h00, rdata.rgb};
         end
         if (read && rdata.sof) aligned <= 1'b1;
         cyc_q <= (state_n == WB_WRITE);
      end
   end

   assign wshb.adr    = adr_q;
   assign wshb.dat_ms = dat_q;
   assign wshb.cyc    = cyc_q;
   assign wshb.stb    = cyc_q;
   assign wshb.sel    = 4'b1111;
   assign wshb.we     = 1'b1;
   assign wshb.cti    = 3'b000;
   assign wshb.bte    = 2'b00;

   assign unused_dat_sm = ^wshb.dat_sm;

endmodule

// File: rtl/video_capture.sv
// Video capture top: input stage, pixel FSM and async FIFO feeding the Wishbone frame-buffer writer.
// Optional frame/drop counters are built when VIDEO_CAPTURE_STATS_EN is defined.
module video_capture
   import video_capture_pkg::*;
#(
   parameter int          HDISP           = 800,
   parameter int          VDISP           = 480,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          FIFO_DEPTH_LOG2 = 8
) (
   input  logic            pixel_clk,
   input  logic            pixel_rst,
   input  logic            wshb_clk,
   input  logic            wshb_rst,
   input  logic [23:0]     vid_rgb,
   input  logic            vid_hs,
   input  logic            vid_vs,
   input  logic            vid_blank,
   output logic            capturing,
   output logic            frame_err,
`ifdef VIDEO_CAPTURE_STATS_EN
   output logic [15:0]     frame_cnt,
   output logic [15:0]     drop_cnt,
`endif
   video_capture_if.master wshb
);

   localparam int COL_W  = $clog2(HDISP + 1);
   localparam int LINE_W = $clog2(VDISP + 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(HDISP);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(VDISP);

   logic [23:0]       rgb_q;
   logic              vs_q, vs_d, blank_q, blank_d;
   logic              vs_fall, blank_fall;
   pix_state_t        state, state_n, cur;
   logic [COL_W-1:0]  col_cnt, col_n;
   logic [LINE_W-1:0] line_cnt, line_n;
   logic              wr_req, sof, err_n, wfull, rempty, fifo_read;
   logic [1:0]        fifo_wrst_sync;
   fifo_word_t        wr_word, rd_word;
   logic              unused_hs;

   assign unused_hs = vid_hs;

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         rgb_q   <= '0;
         vs_q    <= 1'b0;
         vs_d    <= 1'b0;
         blank_q <= 1'b0;
         blank_d <= 1'b0;
      end else begin
         rgb_q   <= vid_rgb;
         vs_q    <= vid_vs;
         vs_d    <= vs_q;
         blank_q <= vid_blank;
         blank_d <= blank_q;
      end
   end

   assign vs_fall    = vs_d & ~vs_q;
   assign blank_fall = blank_d & ~blank_q;

   // The vs edge is resolved first into 'cur'; the pixel of the same cycle is then
   // handled under the rules of 'cur', so a pixel coinciding with vs fall becomes sof.
   always_comb begin
      cur      = state;
      col_n    = col_cnt;
      line_n   = line_cnt;
      wr_req   = 1'b0;
      sof      = 1'b0;
      err_n    = 1'b0;
      if (vs_fall) begin
         if (state == CAPTURE && line_cnt != LINE_LAST) err_n = 1'b1;
         cur = ARMED;
      end
      state_n = cur;
      case (cur)
         ARMED: begin
            if (blank_q) begin
               wr_req  = 1'b1;
               sof     = 1'b1;
               col_n   = COL_W'(1);
               line_n  = '0;
               state_n = CAPTURE;
            end
         end
         CAPTURE: begin
            // Once the last line is complete, everything up to the next vs fall is ignored.
            if (line_cnt != LINE_LAST) begin
               if (blank_fall) begin
                  if (col_cnt != COL_LAST) begin
                     err_n   = 1'b1;
                     state_n = DROP;
                  end else begin
                     line_n = line_cnt + 1'b1;
                     col_n  = '0;
                  end
               end else if (blank_q) begin
                  wr_req = 1'b1;
                  if (col_cnt != '1) col_n = col_cnt + 1'b1;
               end
            end
         end
         default: ;
      endcase
      if (wr_req && wfull) begin
         wr_req  = 1'b0;
         err_n   = 1'b1;
         state_n = DROP;
      end
   end

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         state     <= IDLE;
         col_cnt   <= '0;
         line_cnt  <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         col_cnt   <= col_n;
         line_cnt  <= line_n;
         frame_err <= err_n;
      end
   end

   assign capturing = (state == CAPTURE);

`ifdef VIDEO_CAPTURE_STATS_EN
   logic frame_done;
   assign frame_done = vs_fall && (state == CAPTURE) && (line_cnt == LINE_LAST);

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         frame_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (frame_done) frame_cnt <= frame_cnt + 16'd1;
         if (err_n)      drop_cnt  <= drop_cnt + 16'd1;
      end
   end
`endif

   // wshb_rst flushes the FIFO; its write side sees the reset with a synchronised release.
   always_ff @(posedge pixel_clk or posedge wshb_rst) begin
      if (wshb_rst) fifo_wrst_sync <= 2'b11;
      else          fifo_wrst_sync <= {fifo_wrst_sync[0], 1'b0};
   end

   assign wr_word.sof = sof;
   assign wr_word.rgb = rgb_q;

   async_fifo #(
      .DATA_WIDTH (25),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .wclk   (pixel_clk),
      .wrst   (fifo_wrst_sync[1]),
      .write  (wr_req),
      .wdata  (wr_word),
      .wfull  (wfull),
      .rclk   (wshb_clk),
      .rrst   (wshb_rst),
      .read   (fifo_read),
      .rdata  (rd_word),
      .rempty (rempty)
   );

   video_capture_wb_writer #(
      .HDISP     (HDISP),
      .VDISP     (VDISP),
      .BASE_ADDR (BASE_ADDR)
   ) u_writer (
      .wshb_clk (wshb_clk),
      .wshb_rst (wshb_rst),
      .rdata    (rd_word),
      .rempty   (rempty),
      .read     (fifo_read),
      .wshb     (wshb)
   );

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture on a 4x2 frame at 0x100 with a 16-deep FIFO.
module tb_video_capture;

   localparam int          HDISP = 4;
   localparam int          VDISP = 2;
   localparam logic [31:0] BASE  = 32'h100;

   logic        pixel_clk = 1'b0, wshb_clk = 1'b0;
   logic        pixel_rst = 1'b1, wshb_rst = 1'b1;
   logic [23:0] vid_rgb   = '0;
   logic        vid_hs = 1'b1, vid_vs = 1'b1, vid_blank = 1'b0;
   logic        capturing, frame_err;
`ifdef VIDEO_CAPTURE_STATS_EN
   logic [15:0] frame_cnt, drop_cnt;
`endif

   video_capture_if bus ();

   int          n_cmp = 0, n_err = 0, err_cnt = 0;
   bit          cap_seen = 1'b0;
   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];
   int          ack_cyc_q[$];
   int          wcyc = 0, wcnt = 0, wait_states = 1;
   bit          ack_en = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 pixel_clk = ~pixel_clk;
   always #4 wshb_clk  = ~wshb_clk;

   video_capture #(
      .HDISP           (HDISP),
      .VDISP           (VDISP),
      .BASE_ADDR       (BASE),
      .FIFO_DEPTH_LOG2 (4)
   ) dut (
      .pixel_clk (pixel_clk),
      .pixel_rst (pixel_rst),
      .wshb_clk  (wshb_clk),
      .wshb_rst  (wshb_rst),
      .vid_rgb   (vid_rgb),
      .vid_hs    (vid_hs),
      .vid_vs    (vid_vs),
      .vid_blank (vid_blank),
      .capturing (capturing),
      .frame_err (frame_err),
`ifdef VIDEO_CAPTURE_STATS_EN
      .frame_cnt (frame_cnt),
      .drop_cnt  (drop_cnt),
`endif
      .wshb      (bus)
   );

   // ---------------- bus slave and monitors ----------------
   assign bus.ack    = bus.cyc && bus.stb && ack_en && (wcnt >= wait_states);
   assign bus.dat_sm = 32'h0;

   always @(posedge wshb_clk) begin
      wcyc <= wcyc + 1;
      if (bus.cyc && bus.stb && !bus.ack) wcnt <= wcnt + 1;
      else                                wcnt <= 0;
   end

   always @(negedge wshb_clk) begin
      if (bus.cyc && bus.stb && bus.ack) begin
         obs_q.push_back({bus.adr, bus.dat_ms});
         ack_cyc_q.push_back(wcyc);
      end
   end

   always @(negedge pixel_clk) begin
      if (frame_err) err_cnt++;
      if (capturing) cap_seen = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic pix_idle(input int n);
      repeat (n) begin
         @(negedge pixel_clk);
         vid_blank = 1'b0;
         vid_vs    = 1'b1;
      end
   endtask

   task automatic vs_pulse();
      repeat (2) begin
         @(negedge pixel_clk);
         vid_blank = 1'b0;
         vid_vs    = 1'b0;
      end
      pix_idle(3);
   endtask

   task automatic line(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         @(negedge pixel_clk);
         vid_vs    = 1'b1;
         vid_blank = 1'b1;
         vid_rgb   = 24'(first + i);
      end
      pix_idle(3);
   endtask

   task automatic frame(input int first);
      vs_pulse();
      line(HDISP, first);
      line(HDISP, first + HDISP);
   endtask

   task automatic expect_px(input int idx, input int val);
      exp_q.push_back({BASE + 32'(4 * idx), 8'h00, 24'(val)});
   endtask

   task automatic expect_frame(input int first);
      for (int i = 0; i < HDISP * VDISP; i++) expect_px(i, first + i);
   endtask

   // ---------------- scoreboard ----------------
   task automatic check_writes(input string tag);
      int          guard;
      logic [63:0] e, o;
      guard = 0;
      while (obs_q.size() < exp_q.size() && guard < 3000) begin
         @(negedge wshb_clk);
         guard++;
      end
      repeat (20) @(negedge wshb_clk);
      chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
         chk(tag, o, e);
      end
      obs_q.delete();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int guard, span;
      repeat (5) @(negedge pixel_clk);

      // reset values
      chk("rst_capturing", 64'(capturing), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      chk("rst_cyc", 64'(bus.cyc), 64'd0);
      chk("rst_stb", 64'(bus.stb), 64'd0);
      chk("rst_adr", 64'(bus.adr), 64'(BASE));
      chk("rst_dat", 64'(bus.dat_ms), 64'd0);
      chk("const_sel", 64'(bus.sel), 64'hF);
      chk("const_we", 64'(bus.we), 64'd1);
      chk("const_cti", 64'(bus.cti), 64'd0);
      chk("const_bte", 64'(bus.bte), 64'd0);
      wshb_rst  = 1'b0;
      pixel_rst = 1'b0;
      ack_en    = 1'b1;
      pix_idle(5);

      // pixels before any vs fall are discarded
      line(HDISP, 200);
      line(HDISP, 210);
      pix_idle(5);
      chk("pre_vs_capturing", 64'(cap_seen), 64'd0);
      check_writes("pre_vs");

      // basic frame, one wait state
      vs_pulse();
      chk("armed_capturing", 64'(capturing), 64'd0);
      line(HDISP, 1);
      chk("capture_capturing", 64'(capturing), 64'd1);
      line(HDISP, 5);
      expect_frame(1);
      check_writes("basic");
      chk("basic_cyc_idle", 64'(bus.cyc), 64'd0);
      chk("basic_no_err", 64'(err_cnt), 64'd0);

      // short second line: error, then the next frame realigns at BASE
      vs_pulse();
      line(HDISP, 9);
      line(3, 13);
      for (int i = 0; i < 7; i++) expect_px(i, 9 + i);
      frame(21);
      expect_frame(21);
      check_writes("short_line");
      chk("short_line_err", 64'(err_cnt), 64'd1);

      // overflow with ack held low
      ack_en = 1'b0;
      frame(31);
      frame(41);
      vs_pulse();
      line(HDISP, 51);
      line(HDISP, 55);
      pix_idle(150);
      chk("stall_no_writes", 64'(obs_q.size()), 64'd0);
      chk("overflow_err", 64'(err_cnt), 64'd2);
      ack_en = 1'b1;
      pix_idle(60);
      frame(61);
      expect_frame(31);
      expect_frame(41);
      expect_px(0, 51);
      expect_frame(61);
      check_writes("overflow");

      // two frames back to back, drained with ack every cycle
      @(negedge pixel_clk);
      pixel_rst = 1'b1;
      @(negedge pixel_clk);
      pixel_rst = 1'b0;
      ack_en      = 1'b0;
      wait_states = 0;
      ack_cyc_q.delete();
      frame(71);
      frame(81);
      vs_pulse();
      pix_idle(5);
`ifdef VIDEO_CAPTURE_STATS_EN
      chk("stats_frame_cnt", 64'(frame_cnt), 64'd2);
      chk("stats_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
      ack_en = 1'b1;
      expect_frame(71);
      expect_frame(81);
      check_writes("b2b");
      span = (ack_cyc_q.size() > 0) ? (ack_cyc_q[$] - ack_cyc_q[0]) : -1;
      chk("b2b_ack_span", 64'(span), 64'd15);
      chk("b2b_err", 64'(err_cnt), 64'd2);

      // wshb_rst during a pending write
      ack_en      = 1'b0;
      wait_states = 1;
      vs_pulse();
      line(HDISP, 91);
      guard = 0;
      while (!bus.cyc && guard < 200) begin
         @(negedge wshb_clk);
         guard++;
      end
      chk("cyc_before_rst", 64'(bus.cyc), 64'd1);
      @(negedge wshb_clk);
      wshb_rst = 1'b1;
      @(negedge wshb_clk);
      chk("rst_mid_cyc", 64'(bus.cyc), 64'd0);
      chk("rst_mid_stb", 64'(bus.stb), 64'd0);
      chk("rst_mid_adr", 64'(bus.adr), 64'(BASE));
      repeat (2) @(negedge wshb_clk);
      wshb_rst = 1'b0;
      ack_en   = 1'b1;
      line(HDISP, 95);
      pix_idle(20);
      check_writes("after_rst");
      frame(101);
      vs_pulse();
      expect_frame(101);
      check_writes("resync");
      chk("final_err", 64'(err_cnt), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
